road_scheduler: RTL and testbench
=================================

// Module: road_scheduler
// PURPOSE
// - Per-scanline sequencer driving road_gen's sprite_number, X, Y and mirror inputs.
// - Holds a small road map of one entry per 32-line band.
// - Scrolls the map vertically once per frame.
// - Steps X across the road in 16-px tiles along each line.
// - Sits between VGA timing and road_gen; road pixel = road_gen.state & road_en.
// PARAMETERS
// - ROW_BITS   4   map address width; legal 1..4; map depth = 2**ROW_BITS.
// - SPEED_W    4   width of scroll speed input.
// PORTS
// - clk          in   1   pixel-domain clock.
// - rst_n        in   1   asynchronous, active-low reset.
// - pix_en       in   1   H_pos advances on this cycle.
// - line_start   in   1   1-clk pulse in h-blank; V_pos valid; >=4 clks before first visible pixel.
// - frame_start  in   1   1-clk pulse in v-blank.
// - H_pos        in   9   current pixel column.
// - V_pos        in   9   current line.
// - speed        in   SPEED_W  scroll lines added per frame.
// - wr_en        in   1   map write strobe.
// - wr_addr      in   ROW_BITS  map entry address.
// - wr_data      in   16  map entry fields:
//     [15:14] sprite, [13:9] left col, [8:4] width in tiles, [3:1] curve (signed), [0] sym.
// - sprite_number out 2   to road_gen.
// - X            out  9   to road_gen; tile left edge.
// - Y            out  5   to road_gen; = scroll[4:0].
// - mirror       out  1   to road_gen.
// - road_en      out  1   high while the current line has tiles left to draw.
// BEHAVIOUR
// - Reset: all outputs 0; scroll=0; map contents 0; FSM=IDLE.
// - Scroll: on frame_start, scroll <= scroll + speed (9-bit wrap); Y follows next clk.
//   - frame_start and line_start in the same clk: the fetch uses the old scroll.
// - Row select: row = (V_pos - scroll)[4+ROW_BITS:5]; subtraction mod 512.
// - FSM IDLE/DONE -> FETCH on line_start; FETCH does a 1-clk sync map read.
// - FETCH -> LOAD.
//   - LOAD latches sprite_number and X = col*16 (mod 512), mirror=0, tiles_left=width.
//   - width==0 -> DONE with road_en=0.
//   - Otherwise -> DRAW with road_en=1.
//   - Outputs are valid 2 clks after line_start.
// - DRAW: on pix_en with H_pos == X+15 (9-bit):
//   - X <= X+16 and tiles_left--; tile index i++.
//   - If sym=1, mirror = (i >= width>>1); if sym=0, mirror stays 0.
//   - When the last tile ends: road_en=0 and -> DONE. X keeps its last value.
// - line_start in any state aborts the current line and re-enters FETCH; the 2-clk latency applies.
// - Map write and fetch of the same addr in the same clk: fetch returns old data.
// - X wrap past 511 continues mod 512; road_gen handles the column compare.
// CONFIGURATION
// - ROAD_SCHED_CURVE_EN defined:
//   - LOAD X = col*16 + sext(curve)*((V_pos-scroll)[4:2]), mod 512.
//   - Offset range is -28..+21 px; this gives sloped edges per band.
// - Not defined: wr_data[3:1] is stored but ignored; X = col*16.
// STRUCTURE
// - road_pkg:
//   - FSM state encoding (IDLE, FETCH, LOAD, DRAW, DONE).
//   - Field bit positions of the map entry.
//   - TILE_W=16, BAND_H=32.
// - Sub-module road_map_ram: 2**ROW_BITS x 16 register file; one write port; one registered read port.
// - Top holds the FSM, scroll register, X stepper and tile counter.
// TESTING
// - Reset mid-DRAW:
//   - Outputs, scroll and FSM go to 0/IDLE asynchronously.
//   - road_en=0 until the next line_start after release.
// - Entry 0 = {sprite 2, col 4, width 4, sym 1}, scroll 0, V_pos=0, line_start:
//   - +2 clk: X=64, sprite_number=2, road_en=1, mirror=0.
//   - After H_pos 79: X=80. After H_pos 95: X=96, mirror=1.
//   - After H_pos 127: road_en=0, FSM=DONE.
// - width=0 entry: road_en stays 0 for the whole line; X/sprite still load.
// - speed=3, 11 frame_starts -> scroll=33, Y=1.
//   - V_pos=40 fetches row 0; V_pos=0 fetches row 14 ((0-33) mod 512 = 479).
// - line_start while DRAW at tile 2 -> FETCH; the new row's X and sprite appear 2 clks later.
// - Write entry 3 in the same clk as a row-3 fetch -> old data used; the next line uses new data.
// - With ROAD_SCHED_CURVE_EN, curve=-1, col 8, line 12 in band -> X=125.
//   - Without the macro -> X=128.

Source files
------------

// File: rtl/road_pkg.sv
// road_pkg - shared constants for the road scheduler: FSM encoding, map entry field positions, tile geometry.
package road_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int TILE_W = 16;
  localparam int BAND_H = 32;

  // Map entry layout: {sprite[1:0], col[4:0], width[4:0], curve[2:0], sym}
  localparam int F_SPR_HI = 15;
  localparam int F_SPR_LO = 14;
  localparam int F_COL_HI = 13;
  localparam int F_COL_LO = 9;
  localparam int F_WID_HI = 8;
  localparam int F_WID_LO = 4;
  localparam int F_CRV_HI = 3;
  localparam int F_CRV_LO = 1;
  localparam int F_SYM    = 0;

endpackage

// File: rtl/road_map_ram.sv
// road_map_ram - 2**ROW_BITS x 16 road map; one write port, one registered read port (read-before-write).
module road_map_ram #(
  parameter int ROW_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_addr,
  input  logic [15:0]         wr_data,
  input  logic [ROW_BITS-1:0] rd_addr,
  output logic [15:0]         rd_data
);

  logic [15:0] r_mem [2**ROW_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ROW_BITS; i++) r_mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

// File: rtl/road_scheduler.sv
// road_scheduler - per-scanline tile sequencer for road_gen; scroll, map fetch, X stepping and mirroring.
// Optional ROAD_SCHED_CURVE_EN adds a per-line signed curve offset to the loaded X.
module road_scheduler
  import road_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int SPEED_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic                line_start,
  input  logic                frame_start,
  input  logic [8:0]          H_pos,
  input  logic [8:0]          V_pos,
  input  logic [SPEED_W-1:0]  speed,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_addr,
  input  logic [15:0]         wr_data,
  output logic [1:0]          sprite_number,
  output logic [8:0]          X,
  output logic [4:0]          Y,
  output logic                mirror,
  output logic                road_en
);

  logic [2:0]          r_state;
  logic [8:0]          r_scroll;
  logic [ROW_BITS-1:0] r_row;
  logic [2:0]          r_vsub;
  logic [1:0]          r_sprite;
  logic [8:0]          r_x;
  logic                r_mirror;
  logic                r_road_en;
  logic [4:0]          r_tiles_left;
  logic [4:0]          r_tile_idx;
  logic [4:0]          r_width;
  logic                r_sym;

  logic [15:0]         w_entry;
  logic [8:0]          w_vofs;
  logic [8:0]          w_col_x;
  logic [8:0]          w_load_x;
  logic [4:0]          w_width;
  logic [4:0]          w_next_idx;
  logic [8:0]          w_x_end;

  road_map_ram #(.ROW_BITS(ROW_BITS)) u_map (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (r_row),
    .rd_data (w_entry)
  );

  assign w_vofs     = V_pos - r_scroll;
  assign w_col_x    = {w_entry[F_COL_HI:F_COL_LO], 4'b0000};
  assign w_width    = w_entry[F_WID_HI:F_WID_LO];
  assign w_next_idx = r_tile_idx + 5'd1;
  assign w_x_end    = r_x + 9'd15;

`ifdef ROAD_SCHED_CURVE_EN
  logic signed [8:0] w_curve_s;
  logic signed [8:0] w_curve_off;
  assign w_curve_s   = {{6{w_entry[F_CRV_HI]}}, w_entry[F_CRV_HI:F_CRV_LO]};
  assign w_curve_off = w_curve_s * $signed({6'b000000, r_vsub});
  assign w_load_x    = w_col_x + $unsigned(w_curve_off);
  logic w_unused;
  assign w_unused = ^w_vofs;
`else
  // Curve bits stay in the map but have no effect in this build.
  assign w_load_x = w_col_x;
  logic w_unused;
  assign w_unused = ^{w_entry[F_CRV_HI:F_CRV_LO], w_vofs, r_vsub};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_scroll     <= '0;
      r_row        <= '0;
      r_vsub       <= '0;
      r_sprite     <= '0;
      r_x          <= '0;
      r_mirror     <= 1'b0;
      r_road_en    <= 1'b0;
      r_tiles_left <= '0;
      r_tile_idx   <= '0;
      r_width      <= '0;
      r_sym        <= 1'b0;
    end else begin
      if (frame_start) r_scroll <= r_scroll + 9'(speed);
      // Row is captured with the pre-update scroll, so a coincident frame_start only affects later lines.
      if (line_start) begin
        r_state   <= ST_FETCH;
        r_row     <= w_vofs[4+ROW_BITS:5];
        r_vsub    <= w_vofs[4:2];
        r_road_en <= 1'b0;
      end else begin
        case (r_state)
          ST_FETCH: r_state <= ST_LOAD;
          ST_LOAD: begin
            r_sprite     <= w_entry[F_SPR_HI:F_SPR_LO];
            r_x          <= w_load_x;
            r_mirror     <= 1'b0;
            r_tiles_left <= w_width;
            r_tile_idx   <= '0;
            r_width      <= w_width;
            r_sym        <= w_entry[F_SYM];
            if (w_width == 5'd0) begin
              r_road_en <= 1'b0;
              r_state   <= ST_DONE;
            end else begin
              r_road_en <= 1'b1;
              r_state   <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            if (pix_en && (H_pos == w_x_end)) begin
              if (r_tiles_left == 5'd1) begin
                r_road_en <= 1'b0;
                r_state   <= ST_DONE;
              end else begin
                r_x          <= r_x + 9'(TILE_W);
                r_tiles_left <= r_tiles_left - 5'd1;
                r_tile_idx   <= w_next_idx;
                if (r_sym) r_mirror <= (w_next_idx >= (r_width >> 1));
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sprite_number = r_sprite;
  assign X             = r_x;
  assign Y             = r_scroll[4:0];
  assign mirror        = r_mirror;
  assign road_en       = r_road_en;

endmodule

// File: tb/tb_road_scheduler.sv
// tb_road_scheduler - directed self-checking bench for road_scheduler.
module tb_road_scheduler;
  import road_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       line_start = 1'b0;
  logic       frame_start = 1'b0;
  logic [8:0] H_pos = '0;
  logic [8:0] V_pos = '0;
  logic [3:0] speed = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0] sprite_number;
  logic [8:0] X;
  logic [4:0] Y;
  logic       mirror;
  logic       road_en;

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt;

  road_scheduler #(.ROW_BITS(4), .SPEED_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_en        (pix_en),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .H_pos         (H_pos),
    .V_pos         (V_pos),
    .speed         (speed),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .sprite_number (sprite_number),
    .X             (X),
    .Y             (Y),
    .mirror        (mirror),
    .road_en       (road_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input logic [1:0] spr, input logic [4:0] col,
                                      input logic [4:0] wid, input logic [2:0] crv, input logic sym);
    return {spr, col, wid, crv, sym};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_line(input logic [8:0] v);
    V_pos = v; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_x", X, 0);
    chk("rst_spr", sprite_number, 0);
    chk("rst_y", Y, 0);
    chk("rst_mirror", mirror, 0);
    chk("rst_road_en", road_en, 0);
    rst_n = 1'b1;
    tick();

    // Entry 0: sprite 2, col 4, width 4, sym
    wr(4'd0, enc(2'd2, 5'd4, 5'd4, 3'd0, 1'b1));
    start_line(9'd0);
    chk("e0_x", X, 64);
    chk("e0_spr", sprite_number, 2);
    chk("e0_en", road_en, 1);
    chk("e0_mirror", mirror, 0);
    for (int h = 0; h < 128; h++) begin
      H_pos = 9'(h); pix_en = 1'b1;
      tick();
      if (h == 79) begin chk("e0_x79", X, 80); chk("e0_m79", mirror, 0); end
      if (h == 95) begin chk("e0_x95", X, 96); chk("e0_m95", mirror, 1); end
      if (h == 127) begin
        chk("e0_en127", road_en, 0);
        chk("e0_state127", dut.r_state, ST_DONE);
        chk("e0_x127", X, 112);
      end
    end
    pix_en = 1'b0;

    // width = 0 entry
    wr(4'd1, enc(2'd1, 5'd5, 5'd0, 3'd0, 1'b0));
    start_line(9'd32);
    chk("w0_x", X, 80);
    chk("w0_spr", sprite_number, 1);
    chk("w0_state", dut.r_state, ST_DONE);
    hi_cnt = 0;
    for (int h = 0; h < 200; h++) begin
      H_pos = 9'(h); pix_en = 1'b1;
      tick();
      if (road_en) hi_cnt++;
    end
    pix_en = 1'b0;
    chk("w0_en_cycles", hi_cnt, 0);

    // Abort mid-DRAW at tile 2
    wr(4'd2, enc(2'd3, 5'd2, 5'd6, 3'd0, 1'b0));
    start_line(9'd0);
    for (int h = 0; h < 96; h++) begin
      H_pos = 9'(h); pix_en = 1'b1;
      tick();
    end
    pix_en = 1'b0;
    chk("ab_x_pre", X, 96);
    chk("ab_state_pre", dut.r_state, ST_DRAW);
    V_pos = 9'd64; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("ab_fetch", dut.r_state, ST_FETCH);
    tick(); tick();
    chk("ab_x", X, 32);
    chk("ab_spr", sprite_number, 3);
    chk("ab_en", road_en, 1);
    chk("ab_mirror", mirror, 0);

    // Write collides with row-3 fetch
    wr(4'd3, enc(2'd1, 5'd1, 5'd2, 3'd0, 1'b0));
    V_pos = 9'd96; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = enc(2'd2, 5'd10, 5'd3, 3'd0, 1'b0);
    tick();
    wr_en = 1'b0;
    tick();
    chk("col_old_x", X, 16);
    chk("col_old_spr", sprite_number, 1);
    start_line(9'd96);
    chk("col_new_x", X, 160);
    chk("col_new_spr", sprite_number, 2);

    // Curve: col 8, curve -1, 12 lines into band 4
    wr(4'd4, enc(2'd0, 5'd8, 5'd1, 3'b111, 1'b0));
    start_line(9'd140);
`ifdef ROAD_SCHED_CURVE_EN
    chk("curve_x", X, 125);
`else
    chk("curve_x", X, 128);
`endif

    // Scroll: speed 3 over 11 frames
    speed = 4'd3; frame_start = 1'b1;
    for (int f = 0; f < 11; f++) tick();
    frame_start = 1'b0;
    chk("scr_val", dut.r_scroll, 33);
    chk("scr_y", Y, 1);
    wr(4'd14, enc(2'd3, 5'd20, 5'd1, 3'd0, 1'b0));
    start_line(9'd40);
    chk("scr_v40_x", X, 64);
    chk("scr_v40_spr", sprite_number, 2);
    start_line(9'd0);
    chk("scr_v0_x", X, 320);
    chk("scr_v0_spr", sprite_number, 3);

    // frame_start together with line_start: fetch uses old scroll (33 -> row 1)
    V_pos = 9'd65; line_start = 1'b1; frame_start = 1'b1;
    tick();
    line_start = 1'b0; frame_start = 1'b0;
    tick(); tick();
    chk("same_x", X, 80);
    chk("same_scroll", dut.r_scroll, 36);
    chk("same_y", Y, 4);

    // Reset mid-DRAW
    start_line(9'd40);
    chk("mr_en_pre", road_en, 1);
    for (int h = 0; h < 20; h++) begin
      H_pos = 9'(h); pix_en = 1'b1;
      tick();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_en", road_en, 0);
    chk("mr_x", X, 0);
    chk("mr_spr", sprite_number, 0);
    chk("mr_y", Y, 0);
    chk("mr_scroll", dut.r_scroll, 0);
    chk("mr_state", dut.r_state, ST_IDLE);
    tick(); tick();
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int h = 20; h < 80; h++) begin
      H_pos = 9'(h); pix_en = 1'b1;
      tick();
      if (road_en) hi_cnt++;
    end
    pix_en = 1'b0;
    chk("mr_en_after", hi_cnt, 0);
    chk("mr_state_after", dut.r_state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
